// File: rtl/iterative_divider.sv
// Radix-2 restoring divide/remainder unit for RV32M in the execute stage.
// Drives div_stall to the hazard unit while an M-extension divide occupies E.
module iterative_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             advance,
  input  logic             kill,
  output logic             div_stall,
  output logic             result_valid,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic             is_signed, a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             div_zero, overflow;
  logic [WIDTH:0]   rem_sh, diff;
  logic [WIDTH-1:0] rem_next, quo_next, quo_fix, rem_fix;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      result_q <= result_d;
    end
  end

  // Operand conditioning and special-case detection on the raw start-cycle inputs.
  always_comb begin
    is_signed = ~op[0];
    a_neg     = is_signed & dividend[WIDTH-1];
    b_neg     = is_signed & divisor[WIDTH-1];
    mag_a     = a_neg ? -dividend : dividend;
    mag_b     = b_neg ? -divisor : divisor;
    div_zero  = (divisor == '0);
    overflow  = is_signed & (dividend == MIN_INT) & (divisor == '1);
  end

  // One restoring step: the WIDTH+1-bit difference's MSB flags a negative trial.
  always_comb begin
    rem_sh   = {rem_q, quo_q[WIDTH-1]};
    diff     = rem_sh - {1'b0, dvs_q};
    rem_next = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
    quo_next = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
    quo_fix  = negq_q ? -quo_next : quo_next;
    rem_fix  = negr_q ? -rem_next : rem_next;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    rem_d        = rem_q;
    quo_d        = quo_q;
    dvs_d        = dvs_q;
    negq_d       = negq_q;
    negr_d       = negr_q;
    result_d     = result_q;
    div_stall    = 1'b0;
    result_valid = 1'b0;

    if (kill) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          div_stall = start & rst_n;
          if (start) begin
            op_d = op;
            if (div_zero || overflow) begin
              if (div_zero) result_d = op[1] ? dividend : '1;
              else          result_d = op[1] ? '0 : MIN_INT;
              state_d = DONE;
            end else begin
              quo_d   = mag_a;
              dvs_d   = mag_b;
              rem_d   = '0;
              negq_d  = a_neg ^ b_neg;
              negr_d  = a_neg;
              cnt_d   = CNT_W'(WIDTH);
              state_d = BUSY;
            end
          end
        end
        BUSY: begin
          div_stall = 1'b1;
          rem_d     = rem_next;
          quo_d     = quo_next;
          cnt_d     = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            result_d = op_q[1] ? rem_fix : quo_fix;
            state_d  = DONE;
          end
        end
        DONE: begin
          result_valid = 1'b1;
          if (advance) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign result = result_q;
  assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_iterative_divider.sv
// Directed-vector bench for iterative_divider: latency, signed/special cases, hold, kill, reset.
module tb_iterative_divider;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] dividend, divisor;
  logic        advance, kill;
  logic        div_stall, result_valid, busy;
  logic [31:0] result;

  int pass_cnt = 0;
  int total_cnt = 0;

  localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;

  iterative_divider #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .dividend(dividend), .divisor(divisor), .advance(advance), .kill(kill),
    .div_stall(div_stall), .result_valid(result_valid), .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  // Call positioned just after a negedge; holds start until result_valid appears
  // (bounded), counting stall cycles. With adv=1 it also steps one cycle into IDLE.
  task automatic do_op(input string name, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res,
                       input int exp_stalls, input bit adv);
    int stalls = 0;
    int cycles = 0;
    start = 1'b1; op = o; dividend = a; divisor = b; advance = adv;
    #1;
    while (!result_valid && cycles < 100) begin
      if (div_stall) stalls++;
      @(negedge clk);
      dividend = $urandom; divisor = $urandom;
      #1;
      cycles++;
    end
    total_cnt++;
    if (!result_valid) $display("FAIL %s timeout: result_valid=%b required 1", name, result_valid);
    else pass_cnt++;
    total_cnt++;
    if (result !== exp_res) $display("FAIL %s result: got %h required %h", name, result, exp_res);
    else pass_cnt++;
    total_cnt++;
    if (stalls !== exp_stalls) $display("FAIL %s stall cycles: got %0d required %0d", name, stalls, exp_stalls);
    else pass_cnt++;
    total_cnt++;
    if (div_stall !== 1'b0) $display("FAIL %s stall in DONE: got %b required 0", name, div_stall);
    else pass_cnt++;
    if (adv) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      total_cnt++;
      if (result_valid !== 1'b0 || busy !== 1'b0)
        $display("FAIL %s valid pulse: valid=%b busy=%b required 0 0", name, result_valid, busy);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; op = DIVU; dividend = '0; divisor = '0;
    advance = 1'b1; kill = 1'b0;
    #12;
    total_cnt++;
    if ({div_stall, result_valid, busy, result} !== 35'd0)
      $display("FAIL reset outputs: stall=%b valid=%b busy=%b result=%h required all 0",
               div_stall, result_valid, busy, result);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_unsigned();
    do_op("divu_100_7", DIVU, 32'd100, 32'd7, 32'd14, 33, 1'b1);
    do_op("remu_100_7", REMU, 32'd100, 32'd7, 32'd2, 33, 1'b1);
  endtask

  task automatic test_signed();
    do_op("div_m7_2", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 1'b1);
    do_op("rem_m7_2", REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 1'b1);
    do_op("rem_7_m2", REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 33, 1'b1);
    do_op("div_min_2", DIV, 32'h8000_0000, 32'd2, 32'hC000_0000, 33, 1'b1);
  endtask

  task automatic test_special();
    do_op("div_5_0", DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1'b1);
    do_op("remu_5_0", REMU, 32'd5, 32'd0, 32'd5, 1, 1'b1);
    do_op("div_min_m1", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b1);
    do_op("rem_min_m1", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 1'b1);
  endtask

  task automatic test_hold();
    do_op("hold_op", DIVU, 32'd100, 32'd7, 32'd14, 33, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      total_cnt++;
      if (result_valid !== 1'b1 || result !== 32'd14 || div_stall !== 1'b0 || busy !== 1'b1)
        $display("FAIL hold cycle %0d: valid=%b result=%h stall=%b busy=%b required 1 0000000e 0 1",
                 i, result_valid, result, div_stall, busy);
      else pass_cnt++;
    end
    advance = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    total_cnt++;
    if (busy !== 1'b0 || result_valid !== 1'b0)
      $display("FAIL hold release: busy=%b valid=%b required 0 0", busy, result_valid);
    else pass_cnt++;
  endtask

  task automatic test_kill();
    start = 1'b1; op = DIVU; dividend = 32'd100; divisor = 32'd7; advance = 1'b1;
    for (int i = 0; i < 10; i++) @(negedge clk);
    kill = 1'b1;
    #1;
    total_cnt++;
    if (div_stall !== 1'b0 || result_valid !== 1'b0 || busy !== 1'b1)
      $display("FAIL kill cycle: stall=%b valid=%b busy=%b required 0 0 1", div_stall, result_valid, busy);
    else pass_cnt++;
    @(negedge clk);
    kill = 1'b0; start = 1'b0;
    #1;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL kill to idle: busy=%b required 0", busy);
    else pass_cnt++;
    do_op("after_kill_9_3", DIVU, 32'd9, 32'd3, 32'd3, 33, 1'b1);
  endtask

  task automatic test_reset_mid();
    start = 1'b1; op = DIVU; dividend = 32'd1000; divisor = 32'd3; advance = 1'b1;
    for (int i = 0; i < 6; i++) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({div_stall, result_valid, busy, result} !== 35'd0)
      $display("FAIL reset mid-busy: stall=%b valid=%b busy=%b result=%h required all 0",
               div_stall, result_valid, busy, result);
    else pass_cnt++;
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_op("divu_max_1", DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33, 1'b1);
  endtask

  task automatic test_back_to_back();
    do_op("b2b_divu", DIVU, 32'd1000, 32'd33, 32'd30, 33, 1'b1);
    do_op("b2b_remu", REMU, 32'd1000, 32'd33, 32'd10, 33, 1'b1);
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_special();
    test_hold();
    test_kill();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/iterative_divider.md
Name: iterative_divider

Overview:
- Multi-cycle RV32M divide/remainder unit in the execute stage; producer of the `div_stall` flag consumed by the hazard unit.
- While a DIV/DIVU/REM/REMU instruction sits in E, it holds `div_stall` high. The hazard unit then freezes PC, F_D and D_E and bubbles E→M until the result is ready.
- Radix-2 restoring algorithm, one quotient bit per cycle, with RISC-V special cases resolved early.

Parameters:
- WIDTH, 32, operand/result width in bits; must be ≥2.
- CNT_W, $clog2(WIDTH+1), iteration counter width; derived, not overridden.

Ports:
- clk  input  1  pipeline clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  E stage holds a valid M-extension divide op (decoded, not a bubble).
- op  input  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU. op[0]=unsigned, op[1]=remainder.
- dividend  input  WIDTH  rs1 value after forwarding.
- divisor  input  WIDTH  rs2 value after forwarding.
- advance  input  1  E stage accepts its next instruction this cycle (D_E enable, effective).
- kill  input  1  E-stage instruction flushed; abort.
- div_stall  output  1  to hazard unit; stall front of pipeline.
- result_valid  output  1  result holds the final value for the instruction in E.
- result  output  WIDTH  quotient or remainder.
- busy  output  1  FSM not IDLE (debug/perf counter).

Behaviour:
- Reset (async, rst_n=0):
  - State=IDLE, counter=0, all datapath registers 0.
  - div_stall=0, result_valid=0, result=0, busy=0.
  - Reset mid-operation discards all state; no result is produced.
- States: IDLE, BUSY, DONE.
- IDLE:
  - div_stall = start & ~kill (combinational, same cycle the op enters E).
  - On start & ~kill at the clock edge:
    - Latch op.
    - Latch |dividend| and |divisor| (magnitudes for signed ops; raw values for unsigned ops).
    - Latch the quotient sign (sign(a) XOR sign(b)) and the remainder sign (sign(a)), signed ops only.
  - Special cases, detected on the raw inputs in the start cycle:
    - divisor==0: quotient = all ones; remainder = dividend.
    - Signed and dividend==MIN_INT and divisor==−1: quotient = MIN_INT; remainder = 0.
    - In either case, register the result and go directly to DONE. div_stall is high for exactly 1 cycle.
  - Otherwise: counter=WIDTH, partial remainder=0, go to BUSY.
- BUSY:
  - div_stall=1 unless kill.
  - Each cycle performs one restoring step:
    - Shift {rem, quo} left by 1.
    - Trial subtract rem−|divisor|, computed in WIDTH+1 bits.
    - If non-negative, keep the difference and set quo[0]=1.
  - Counter decrements each cycle. On the step where counter==1:
    - Apply sign correction (two's-complement negate when the corresponding sign flag is set).
    - Select quotient or remainder by op[1].
    - Register the result and go to DONE.
  - Total: div_stall high for WIDTH+1 cycles (start cycle + WIDTH BUSY cycles); result_valid rises on the next cycle.
- DONE:
  - div_stall=0, result_valid=1, result stable.
  - advance=1: go to IDLE at the edge.
  - advance=0 (e.g. cache stall freezing E): hold DONE indefinitely. start remains high during the hold and must not relaunch the operation.
- kill (any state):
  - div_stall=0 and result_valid=0 combinationally in that cycle.
  - Next state IDLE; kill has priority over start and advance.
- Back-to-back divides: DONE→IDLE on advance. A new start in the following cycle begins a fresh operation; there is no operand sharing.
- Operand inputs are ignored outside the IDLE start cycle.
- result holds its last value in IDLE and is qualified only by result_valid.

Test Plan:
- DIVU 100/7, advance=1 in DONE → div_stall high exactly 33 cycles; result_valid pulse of 1 cycle; result=14. Repeat with REMU → 2.
- DIV −7/2 → −3 (0xFFFFFFFD); REM −7/2 → −1 (0xFFFFFFFF); REM 7/−2 → 1; DIV 0x80000000/2 → 0xC0000000.
- DIV 5/0 → 0xFFFFFFFF; REMU 5/0 → 5; DIV 0x80000000/−1 → 0x80000000; REM 0x80000000/−1 → 0. Each stalls exactly 1 cycle.
- DONE with advance=0 for 3 cycles and start held high → result_valid and result stable, div_stall=0, no restart; advance=1 → IDLE next cycle.
- kill at BUSY cycle 10 → div_stall=0 that cycle, then IDLE. Immediate new start 9/3 → 3 with full latency.
- rst_n low mid-BUSY → all outputs 0 asynchronously. After release, DIVU 0xFFFFFFFF/1 → 0xFFFFFFFF; back-to-back DIVU then REMU produce correct independent results.
